paralelo_serial_param: RTL

Parametrised parallel-to-serial converter for the PHY transmit path. It runs entirely in the bit-rate clock domain and accepts WIDTH-bit words through a valid/ready handshake into a one-entry holding register. It emits one bit per cycle in fixed WIDTH-cycle slots, and fills empty slots with a configurable idle/comma word. It also flags word boundaries and whether each slot carries data or idle, so the downstream serial receiver can align to the stream.

---
 rtl/paralelo_serial_param_pkg.sv | 18 +
 rtl/paralelo_serial_param_hold.sv | 35 +++
 rtl/paralelo_serial_param.sv | 76 +++++++
 3 files changed

// File: rtl/paralelo_serial_param_pkg.sv
// Shared PHY transmit constants and helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package paralelo_serial_param_pkg;

   // K28.5 comma character, the default idle/alignment word
   localparam logic [7:0] K28_5 = 8'hBC;

   // Serial bit order selectors
   localparam bit BIT_ORDER_MSB = 1'b1;
   localparam bit BIT_ORDER_LSB = 1'b0;

   // Width of a counter that must reach w-1; never narrower than one bit
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/paralelo_serial_param_hold.sv
// One-entry holding register between the word producer and the slot shifter.
// Latency: a word accepted on one edge is visible on word/full after that edge.
// Backpressure: ready_out = ~full (registered); the shifter empties it with take.
module paralelo_serial_param_hold #(
   parameter int WIDTH = 8
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic             take,
   output logic [WIDTH-1:0] word,
   output logic             full
);

   assign ready_out = ~full;

   // Consume on a load edge when full; otherwise accept a new word if empty.
   // A full register never accepts, so a load and an accept cannot collide.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         full <= 1'b0;
         word <= '0;
      end else if (full) begin
         if (take) begin
            full <= 1'b0;
         end
      end else if (valid_in) begin
         word <= data_in;
         full <= 1'b1;
      end
   end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter emitting one bit per clk_32f in WIDTH-cycle slots.
// Latency: 1..WIDTH cycles from accept to first data bit; first post-reset slot is idle.
// Backpressure: one-entry hold; ready_out low while full, stream never stalls (idle fill).
module paralelo_serial_param
   import paralelo_serial_param_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5),
   parameter bit               MSB_FIRST = BIT_ORDER_MSB
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             data_out,
   output logic             sof_out,
   output logic             valid_out
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] hold_word;
   logic             hold_full;
   logic             load;
   logic [WIDTH-1:0] slot_word;

   // The last bit of a slot is on the wire; the next edge starts a new slot
   assign load      = (bit_cnt == LAST);
   assign slot_word = hold_full ? hold_word : IDLE_WORD;

   paralelo_serial_param_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .take      (load),
      .word      (hold_word),
      .full      (hold_full)
   );

   // Slot counter and shifter: load a data or idle word, then shift it out bit by bit
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         bit_cnt   <= LAST;
         sh        <= IDLE_WORD;
         data_out  <= 1'b0;
         sof_out   <= 1'b0;
         valid_out <= 1'b0;
      end else if (load) begin
         bit_cnt   <= '0;
         sh        <= slot_word;
         data_out  <= MSB_FIRST ? slot_word[WIDTH-1] : slot_word[0];
         sof_out   <= 1'b1;
         valid_out <= hold_full;
      end else begin
         bit_cnt <= bit_cnt + 1'b1;
         sof_out <= 1'b0;
         // sh keeps the bit currently on the wire at its head; move the next one up
         if (MSB_FIRST) begin
            data_out <= sh[WIDTH-2];
            sh       <= {sh[WIDTH-2:0], 1'b0};
         end else begin
            data_out <= sh[1];
            sh       <= {1'b0, sh[WIDTH-1:1]};
         end
      end
   end

endmodule
